// File: rtl/uart_pkg.sv
// Constants shared by the UART receive and transmit buffering blocks.
package uart_pkg;

    localparam int UART_DW         = 8;
    localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Register/bus-side view of the UART receive FIFO: byte strobe in, FWFT read port out, status and config.
interface uart_rx_fifo_if #(
    parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic                        cfg_clr;
    logic [AW:0]                 cfg_wm;
    logic [15:0]                 cfg_tmo;
    logic                        rx_valid;
    logic [uart_pkg::UART_DW-1:0] rx_data;
    logic                        rd_valid;
    logic [uart_pkg::UART_DW-1:0] rd_data;
    logic                        rd_ready;
    logic [AW:0]                 level;
    logic                        full;
    logic                        empty;
    logic                        ovf;
    logic                        ovf_clr;
    logic                        irq_wm;
    logic                        irq_tmo;

    modport master (
        output cfg_clr, cfg_wm, cfg_tmo, rx_valid, rx_data, rd_ready, ovf_clr,
        input  rd_valid, rd_data, level, full, empty, ovf, irq_wm, irq_tmo
    );

    modport slave (
        input  cfg_clr, cfg_wm, cfg_tmo, rx_valid, rx_data, rd_ready, ovf_clr,
        output rd_valid, rd_data, level, full, empty, ovf, irq_wm, irq_tmo
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// Register-array storage: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
    parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH,
    parameter int DW    = uart_pkg::UART_DW
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures strobed bytes, FWFT read port, fill level, sticky overflow,
// watermark and idle-timeout interrupts.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;

    logic [AW:0]         level_w;
    logic                full_w;
    logic                empty_w;
    logic                pop_w;
    logic                push_w;
    logic                drop_w;
    logic                ram_we;
    logic [UART_DW-1:0]  ram_rdata;

    // Pointers carry one extra MSB so equal low bits can still be told apart as full or empty.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (level_w == (AW+1)'(DEPTH));
    assign empty_w = (level_w == '0);

    assign pop_w  = !empty_w && bus.rd_ready;
    assign push_w = bus.rx_valid && (!full_w || pop_w);
    assign drop_w = bus.rx_valid && full_w && !pop_w;
    assign ram_we = push_w && !bus.cfg_clr;

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .DW    (UART_DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.rx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        tmo_cnt_d = tmo_cnt_q;

        if (bus.cfg_clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ovf_d     = 1'b0;
            tmo_cnt_d = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            // A drop in the same cycle as ovf_clr must leave the flag set.
            if (drop_w) begin
                ovf_d = 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_d = 1'b0;
            end

            if (push_w || pop_w || empty_w) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q != 16'hFFFF) begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // All outputs decode straight from registers, so an async reset clears them without a clock.
    assign bus.level    = level_w;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.rd_valid = !empty_w;
    assign bus.rd_data  = empty_w ? '0 : ram_rdata;
    assign bus.ovf      = ovf_q;
    assign bus.irq_wm   = (bus.cfg_wm != '0) && (level_w >= bus.cfg_wm);
    assign bus.irq_tmo  = (bus.cfg_tmo != '0) && !empty_w && (tmo_cnt_q >= bus.cfg_tmo);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a byte queue, an overflow flag and a count of idle cycles.
    byte unsigned mq[$];
    bit           m_ovf;
    int           m_idle;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_idle = 0;
        end else if (bus.cfg_clr) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_idle = 0;
        end else begin
            bit was_empty;
            bit popped;
            bit pushed;
            bit dropped;
            was_empty = (mq.size() == 0);
            popped    = !was_empty && bus.rd_ready;
            pushed    = 1'b0;
            dropped   = 1'b0;
            if (popped) void'(mq.pop_front());
            if (bus.rx_valid) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(bus.rx_data);
                    pushed = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
            if (pushed || popped || was_empty) m_idle = 0;
            else if (m_idle < 65535) m_idle = m_idle + 1;
        end
    end

    always @(negedge clk) begin
        int n;
        n = mq.size();
        check("level",    32'(bus.level),    32'(n));
        check("empty",    32'(bus.empty),    32'(n == 0));
        check("full",     32'(bus.full),     32'(n == DEPTH));
        check("rd_valid", 32'(bus.rd_valid), 32'(n != 0));
        check("rd_data",  32'(bus.rd_data),  (n != 0) ? 32'(mq[0]) : 32'h0);
        check("ovf",      32'(bus.ovf),      32'(m_ovf));
        check("irq_wm",   32'(bus.irq_wm),
              32'((bus.cfg_wm != 0) && (n >= int'(bus.cfg_wm))));
        check("irq_tmo",  32'(bus.irq_tmo),
              32'((bus.cfg_tmo != 0) && (n != 0) && (m_idle >= int'(bus.cfg_tmo))));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic flush();
        bus.cfg_clr = 1'b1;
        step();
        bus.cfg_clr = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_b;

        bus.cfg_clr  = 1'b0;
        bus.cfg_wm   = '0;
        bus.cfg_tmo  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;

        repeat (2) step();
        check("rst_level", 32'(bus.level), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_rdata", 32'(bus.rd_data), 0);
        rst = 1'b0;
        step();

        // Basic ordering
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'h7E);
        check("basic_level", 32'(bus.level), 3);
        bus.rd_ready = 1'b1;
        check("basic_pop0", 32'(bus.rd_data), 32'hA5);
        step();
        check("basic_pop1", 32'(bus.rd_data), 32'h3C);
        step();
        check("basic_pop2", 32'(bus.rd_data), 32'h7E);
        step();
        bus.rd_ready = 1'b0;
        check("basic_empty", 32'(bus.empty), 1);
        check("basic_rdata0", 32'(bus.rd_data), 0);

        // Overflow
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        check("ovf_full16", 32'(bus.full), 1);
        check("ovf_pre", 32'(bus.ovf), 0);
        push_byte(8'hEE);
        check("ovf_level", 32'(bus.level), 16);
        check("ovf_set", 32'(bus.ovf), 1);
        check("ovf_head", 32'(bus.rd_data), 32'h10);
        bus.ovf_clr = 1'b1;
        push_byte(8'hEF);
        bus.ovf_clr = 1'b0;
        check("ovf_setwins", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", 32'(bus.ovf), 0);

        // Full with simultaneous pop and push
        bus.rd_ready = 1'b1;
        push_byte(8'h55);
        bus.rd_ready = 1'b0;
        check("fpp_level", 32'(bus.level), 16);
        check("fpp_ovf", 32'(bus.ovf), 0);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h11 + i) : 8'h55;
            check("fpp_drain", 32'(bus.rd_data), 32'(exp_b));
            step();
        end
        check("fpp_empty", 32'(bus.empty), 1);

        // Wrap-around with one byte in flight
        for (int i = 0; i < 41; i++) begin
            bus.rx_valid = (i < 40);
            bus.rx_data  = 8'($urandom);
            step();
            check("wrap_level_le1", 32'(bus.level <= 1), 1);
        end
        bus.rx_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("wrap_empty", 32'(bus.empty), 1);

        // Watermark and timeout
        bus.cfg_wm  = 5'd4;
        bus.cfg_tmo = 16'd100;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check("wm_below", 32'(bus.irq_wm), 0);
        push_byte(8'h04);
        check("wm_rise", 32'(bus.irq_wm), 1);
        n = 0;
        while (!bus.irq_tmo && n < 200) begin
            step();
            n++;
        end
        check("tmo_latency", 32'(n), 100);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check("tmo_fall", 32'(bus.irq_tmo), 0);
        check("wm_fall", 32'(bus.irq_wm), 0);

        // Randomized traffic with config changes
        for (int i = 0; i < 500; i++) begin
            bus.rx_valid = ($urandom_range(0, 2) != 0);
            bus.rx_data  = 8'($urandom);
            bus.rd_ready = ($urandom_range(0, 2) == 0);
            bus.ovf_clr  = ($urandom_range(0, 15) == 0);
            bus.cfg_clr  = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 20) == 0) bus.cfg_wm  = 5'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 20) == 0) bus.cfg_tmo = 16'($urandom_range(0, 8));
            if ($urandom_range(0, 80) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rd_ready = 1'b0;
                repeat (10) step();
            end
            step();
        end
        bus.rx_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.cfg_clr  = 1'b0;
        bus.cfg_wm   = '0;
        bus.cfg_tmo  = '0;
        flush();

        // Flush and asynchronous reset
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        bus.rd_ready = 1'b1;
        repeat (11) step();
        bus.rd_ready = 1'b0;
        check("fl_level5", 32'(bus.level), 5);
        check("fl_ovf1", 32'(bus.ovf), 1);
        bus.cfg_clr  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hC3;
        step();
        bus.cfg_clr  = 1'b0;
        bus.rx_valid = 1'b0;
        check("fl_level0", 32'(bus.level), 0);
        check("fl_ovf0", 32'(bus.ovf), 0);
        check("fl_lost", 32'(bus.empty), 1);

        bus.cfg_wm = 5'd2;
        push_byte(8'h9A);
        push_byte(8'h9B);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h9C;
        check("rs_pre_wm", 32'(bus.irq_wm), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_level", 32'(bus.level), 0);
        check("rs_empty", 32'(bus.empty), 1);
        check("rs_rd_valid", 32'(bus.rd_valid), 0);
        check("rs_rd_data", 32'(bus.rd_data), 0);
        check("rs_full", 32'(bus.full), 0);
        check("rs_ovf", 32'(bus.ovf), 0);
        check("rs_irq_wm", 32'(bus.irq_wm), 0);
        check("rs_irq_tmo", 32'(bus.irq_tmo), 0);
        bus.rx_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
